// File: rtl/id_issue.sv
// id_issue: in-order issue stage between id_dec and EX.
// Hazard-checked prefix accept, ARF read, S1 register, WB forwarding.
//
// Ports:
//   clk, rst (async, active-low), flush, stall
//   id_*        per-slot decoded bundle from the decoder
//   id_pop_cnt  number of slots accepted this cycle
//   arf_*       register-file read ports (rs1 at 2i, rs2 at 2i+1)
//   wb_*        writeback / bypass ports
//   ex_*        registered issue bundle with forwarded operands
module id_issue #(
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int CONFIG_DW            = 64,
  parameter int CONFIG_REG_AW        = 5,
  parameter int CONFIG_PAYLOAD_W     = 128,
  parameter int CONFIG_NWB           = 2,
  localparam int IW  = 1 << CONFIG_P_ISSUE_WIDTH,
  localparam int DW  = CONFIG_DW,
  localparam int AW  = CONFIG_REG_AW,
  localparam int PW  = CONFIG_PAYLOAD_W,
  localparam int NWB = CONFIG_NWB,
  localparam int PC  = CONFIG_P_ISSUE_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall,
  input  logic [IW-1:0]        id_valid,
  input  logic [IW-1:0]        id_single_fu,
  input  logic [IW-1:0]        id_lng,
  input  logic [IW-1:0]        id_we,
  input  logic [IW*AW-1:0]     id_waddr,
  input  logic [IW-1:0]        id_rs1_re,
  input  logic [IW*AW-1:0]     id_rs1_addr,
  input  logic [IW-1:0]        id_rs2_re,
  input  logic [IW*AW-1:0]     id_rs2_addr,
  input  logic [IW*PW-1:0]     id_payload,
  output logic [PC-1:0]        id_pop_cnt,
  output logic [2*IW-1:0]      arf_RE,
  output logic [2*IW*AW-1:0]   arf_RADDR,
  input  logic [2*IW*DW-1:0]   arf_RDATA,
  input  logic [NWB-1:0]       wb_we,
  input  logic [NWB-1:0]       wb_lng,
  input  logic [NWB*AW-1:0]    wb_waddr,
  input  logic [NWB*DW-1:0]    wb_wdata,
  output logic [IW-1:0]        ex_valid,
  output logic [IW*PW-1:0]     ex_payload,
  output logic [IW*DW-1:0]     ex_operand1,
  output logic [IW*DW-1:0]     ex_operand2
);

  localparam int NR = 1 << AW;
  localparam int NS = 2 * IW;

  logic [IW-1:0][AW-1:0]  waddr;
  logic [IW-1:0][AW-1:0]  a1;
  logic [IW-1:0][AW-1:0]  a2;
  logic [NWB-1:0][AW-1:0] wba;
  logic [NWB-1:0][DW-1:0] wbd;
  logic [NS-1:0][DW-1:0]  rdata;

  assign waddr = id_waddr;
  assign a1    = id_rs1_addr;
  assign a2    = id_rs2_addr;
  assign wba   = wb_waddr;
  assign wbd   = wb_wdata;
  assign rdata = arf_RDATA;

  logic [NR-1:0] sb_q;
  logic [NR-1:0] lclr;
  logic [NR-1:0] sb_eff;
  logic [NR-1:0] sset;

  // Long-latency writebacks retire scoreboard entries.
  always_comb begin
    lclr = '0;
    for (int p = 0; p < NWB; p++)
      if (wb_we[p] & wb_lng[p]) lclr[wba[p]] = 1'b1;
  end

  // A retiring writeback in the same cycle already removes the hazard.
  assign sb_eff = sb_q & ~lclr;

  logic [IW-1:0] raw;
  logic [IW-1:0] sbh;

  always_comb begin
    raw = '0;
    sbh = '0;
    for (int k = 0; k < IW; k++) begin
      sbh[k] = (id_rs1_re[k] & (|a1[k]) & sb_eff[a1[k]])
             | (id_rs2_re[k] & (|a2[k]) & sb_eff[a2[k]]);
      for (int j = 0; j < k; j++)
        if (id_we[j] & (|waddr[j]) &
            ((id_rs1_re[k] & (a1[k] == waddr[j])) |
             (id_rs2_re[k] & (a2[k] == waddr[j]))))
          raw[k] = 1'b1;
    end
  end

  logic [IW-1:0] ok;
  logic          run;

  // Longest in-order prefix of hazard-free slots.
  always_comb begin
    ok  = '0;
    run = 1'b1;
    for (int k = 0; k < IW; k++) begin
      run = run & id_valid[k] & ~sbh[k] & ~raw[k]
          & ((k == 0) | ~id_single_fu[k]);
      ok[k] = run;
    end
  end

  logic          go;
  logic [IW-1:0] acc;

  assign go  = rst & ~stall & ~flush;
  assign acc = ok & {IW{go}};

  always_comb begin
    id_pop_cnt = '0;
    for (int k = 0; k < IW; k++)
      id_pop_cnt = id_pop_cnt + PC'(acc[k]);
  end

  logic [NS-1:0]         src_re;
  logic [NS-1:0][AW-1:0] src_a;

  always_comb begin
    src_re = '0;
    src_a  = '0;
    for (int k = 0; k < IW; k++) begin
      src_re[2*k]   = id_rs1_re[k];
      src_re[2*k+1] = id_rs2_re[k];
      src_a[2*k]    = a1[k];
      src_a[2*k+1]  = a2[k];
    end
  end

  logic [NS-1:0] acc2;

  always_comb begin
    acc2 = '0;
    for (int k = 0; k < IW; k++) begin
      acc2[2*k]   = acc[k];
      acc2[2*k+1] = acc[k];
    end
  end

  assign arf_RE    = src_re & acc2;
  assign arf_RADDR = src_a;

  always_comb begin
    sset = '0;
    for (int k = 0; k < IW; k++)
      if (acc[k] & id_lng[k] & id_we[k] & (|waddr[k]))
        sset[waddr[k]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       sb_q <= '0;
    else if (flush) sb_q <= '0;
    else            sb_q <= sb_eff | sset;
  end

  logic                  fresh;
  logic [NS-1:0]         s_re;
  logic [NS-1:0][AW-1:0] s_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= '0;
      ex_payload <= '0;
      fresh      <= 1'b0;
      s_re       <= '0;
      s_a        <= '0;
    end else if (flush) begin
      ex_valid <= '0;
      fresh    <= 1'b0;
    end else if (stall) begin
      fresh <= 1'b0;
    end else begin
      ex_valid   <= acc;
      ex_payload <= id_payload;
      fresh      <= 1'b1;
      s_re       <= src_re;
      s_a        <= src_a;
    end
  end

  logic [NS-1:0][DW-1:0] hold_q;
  logic [NS-1:0][DW-1:0] opnd;

  // ARF data is only valid the cycle after the read; afterwards the
  // hold register carries the value, refreshed by any writeback hit.
  always_comb begin
    opnd = '0;
    for (int s = 0; s < NS; s++) begin
      opnd[s] = fresh ? rdata[s] : hold_q[s];
      for (int p = 0; p < NWB; p++)
        if (wb_we[p] && (wba[p] == s_a[s])) opnd[s] = wbd[p];
      if (!s_re[s] || (s_a[s] == '0)) opnd[s] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_q <= '0;
    else      hold_q <= opnd;
  end

  logic [IW-1:0][DW-1:0] op1;
  logic [IW-1:0][DW-1:0] op2;

  always_comb begin
    op1 = '0;
    op2 = '0;
    for (int k = 0; k < IW; k++) begin
      op1[k] = opnd[2*k];
      op2[k] = opnd[2*k+1];
    end
  end

  assign ex_operand1 = op1;
  assign ex_operand2 = op2;

endmodule

// File: tb/tb_id_issue.sv
// tb_id_issue: randomized + directed scoreboard bench for id_issue.
// Reference keeps an architectural register file and pending-load set.
module tb_id_issue;
  localparam int P   = 1;
  localparam int IW  = 1 << P;
  localparam int DW  = 64;
  localparam int AW  = 5;
  localparam int PW  = 128;
  localparam int NWB = 2;
  localparam int NR  = 1 << AW;

  logic clk = 1'b0;
  logic rst, flush, stall;
  logic [IW-1:0] v, sfu, lng, we, re1, re2;
  logic [IW-1:0][AW-1:0] wa, a1, a2;
  logic [IW-1:0][PW-1:0] pl;
  logic [P:0] pop;
  logic [2*IW-1:0] are;
  logic [2*IW-1:0][AW-1:0] araddr;
  logic [2*IW-1:0][DW-1:0] ardata;
  logic [NWB-1:0] wwe, wlng;
  logic [NWB-1:0][AW-1:0] wwa;
  logic [NWB-1:0][DW-1:0] wwd;
  logic [IW-1:0] exv;
  logic [IW-1:0][PW-1:0] expl;
  logic [IW-1:0][DW-1:0] eo1, eo2;

  always #5 clk = ~clk;

  id_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .id_valid(v), .id_single_fu(sfu), .id_lng(lng), .id_we(we),
    .id_waddr(wa), .id_rs1_re(re1), .id_rs1_addr(a1),
    .id_rs2_re(re2), .id_rs2_addr(a2), .id_payload(pl),
    .id_pop_cnt(pop), .arf_RE(are), .arf_RADDR(araddr),
    .arf_RDATA(ardata), .wb_we(wwe), .wb_lng(wlng),
    .wb_waddr(wwa), .wb_wdata(wwd), .ex_valid(exv),
    .ex_payload(expl), .ex_operand1(eo1), .ex_operand2(eo2)
  );

  typedef struct packed {
    logic [IW-1:0]         m;
    logic [IW-1:0][PW-1:0] pl;
    logic [IW-1:0]         r1;
    logic [IW-1:0]         r2;
    logic [IW-1:0][AW-1:0] a1;
    logic [IW-1:0][AW-1:0] a2;
  } bundle_t;

  bundle_t q[$];
  logic [DW-1:0] regs[NR];
  bit pend[NR];
  bit quiet;
  int checks = 0;
  int errors = 0;
  int exp_pop;
  logic [IW-1:0] exp_acc;
  logic [2*IW-1:0] exp_re;

  task automatic check(input string nm, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural value of a register as seen this cycle.
  function automatic logic [DW-1:0] cur(input logic r,
                                        input logic [AW-1:0] a);
    logic [DW-1:0] d;
    if (!r || a == 0) return '0;
    d = regs[a];
    for (int p = 0; p < NWB; p++)
      if (wwe[p] && wwa[p] == a) d = wwd[p];
    return d;
  endfunction

  function automatic bit lngwb(input logic [AW-1:0] a);
    for (int p = 0; p < NWB; p++)
      if (wwe[p] && wlng[p] && wwa[p] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy(input logic r, input logic [AW-1:0] a);
    return r && a != 0 && pend[a] && !lngwb(a);
  endfunction

  // Write-first register file with one-cycle read latency.
  always @(posedge clk)
    for (int s = 0; s < 2*IW; s++)
      ardata[s] <= cur(1'b1, araddr[s]);

  task automatic model_accept();
    bit run, h;
    exp_acc = '0;
    exp_pop = 0;
    exp_re  = '0;
    run = rst && !stall && !flush;
    for (int k = 0; k < IW; k++) begin
      h = !v[k] || (k > 0 && sfu[k]) ||
          busy(re1[k], a1[k]) || busy(re2[k], a2[k]);
      for (int j = 0; j < k; j++)
        if (we[j] && wa[j] != 0 &&
            ((re1[k] && a1[k] == wa[j]) || (re2[k] && a2[k] == wa[j])))
          h = 1'b1;
      if (h) run = 1'b0;
      if (run) begin
        exp_acc[k] = 1'b1;
        exp_pop++;
        exp_re[2*k]   = re1[k];
        exp_re[2*k+1] = re2[k];
      end
    end
  endtask

  task automatic commit();
    bundle_t b;
    for (int p = 0; p < NWB; p++)
      if (wwe[p] && wwa[p] != 0) regs[wwa[p]] = wwd[p];
    if (flush) begin
      for (int a = 0; a < NR; a++) pend[a] = 1'b0;
    end else begin
      for (int a = 1; a < NR; a++)
        if (lngwb(AW'(a))) pend[a] = 1'b0;
      for (int k = 0; k < IW; k++)
        if (exp_acc[k] && lng[k] && we[k] && wa[k] != 0)
          pend[wa[k]] = 1'b1;
    end
    if (exp_acc != 0) begin
      b.m = exp_acc; b.pl = pl;
      b.r1 = re1; b.r2 = re2; b.a1 = a1; b.a2 = a2;
      q.push_back(b);
    end
  endtask

  task automatic step();
    model_accept();
    @(posedge clk);
    commit();
    #1;
  endtask

  always @(negedge clk) begin
    bundle_t b;
    if (!quiet) begin
      check("pop_cnt", pop, exp_pop);
      check("arf_re", are, exp_re);
      if (q.size() == 0) begin
        check("ex_valid_idle", exv, 0);
      end else begin
        b = q[0];
        check("ex_valid", exv, b.m);
        for (int k = 0; k < IW; k++)
          if (b.m[k]) begin
            check("payload", expl[k], b.pl[k]);
            check("operand1", eo1[k], cur(b.r1[k], b.a1[k]));
            check("operand2", eo2[k], cur(b.r2[k], b.a2[k]));
          end
        if (flush || !stall) void'(q.pop_front());
      end
    end
  end

  task automatic clear_in();
    v = '0; sfu = '0; lng = '0; we = '0; re1 = '0; re2 = '0;
    wa = '0; a1 = '0; a2 = '0;
    for (int k = 0; k < IW; k++)
      pl[k] = {$urandom, $urandom, $urandom, $urandom};
    stall = 0; flush = 0;
    wwe = '0; wlng = '0; wwa = '0; wwd = '0;
  endtask

  task automatic slot0(input logic l, input logic w, input int wd,
                       input logic r1, input int s1,
                       input logic r2, input int s2);
    v[0] = 1; lng[0] = l; we[0] = w; wa[0] = AW'(wd);
    re1[0] = r1; a1[0] = AW'(s1); re2[0] = r2; a2[0] = AW'(s2);
  endtask

  task automatic rand_in();
    for (int k = 0; k < IW; k++) begin
      v[k]   = ($urandom_range(0, 9) < 8);
      sfu[k] = ($urandom_range(0, 9) == 0);
      lng[k] = ($urandom_range(0, 3) == 0);
      we[k]  = ($urandom_range(0, 3) != 0);
      re1[k] = ($urandom_range(0, 3) != 0);
      re2[k] = ($urandom_range(0, 3) != 0);
      wa[k]  = AW'($urandom_range(0, 7));
      a1[k]  = AW'($urandom_range(0, 7));
      a2[k]  = AW'($urandom_range(0, 7));
      pl[k]  = {$urandom, $urandom, $urandom, $urandom};
    end
    stall = ($urandom_range(0, 6) == 0);
    flush = ($urandom_range(0, 19) == 0);
    for (int p = 0; p < NWB; p++) begin
      wwe[p]  = $urandom_range(0, 1);
      wlng[p] = ($urandom_range(0, 2) == 0);
      wwa[p]  = AW'($urandom_range(0, 7));
      wwd[p]  = {$urandom, $urandom};
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_exv"}, exv, 0);
    check({tag, "_pop"}, pop, 0);
    check({tag, "_re"}, are, 0);
    for (int k = 0; k < IW; k++) begin
      check({tag, "_pl"}, expl[k], 0);
      check({tag, "_op1"}, eo1[k], 0);
      check({tag, "_op2"}, eo2[k], 0);
    end
  endtask

  initial begin
    for (int a = 0; a < NR; a++) begin
      regs[a] = (a == 0) ? '0 : {$urandom, $urandom};
      pend[a] = 1'b0;
    end
    quiet = 1; rst = 0;
    exp_pop = 0; exp_acc = '0; exp_re = '0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    v = '1;
    #1;
    reset_check("reset");
    clear_in();
    rst = 1;
    @(posedge clk); #1;
    quiet = 0;

    // In-window RAW: slot1 reads r3 written by slot0.
    slot0(0, 1, 3, 1, 1, 1, 2);
    v[1] = 1; we[1] = 1; wa[1] = 4;
    re1[1] = 1; a1[1] = 3; re2[1] = 1; a2[1] = 5;
    #1 check("raw_pop", pop, 1);
    step();
    clear_in();
    slot0(0, 1, 4, 1, 3, 1, 5);
    #1 check("raw_next_pop", pop, 1);
    step();

    // Load-use blocked until the long writeback.
    clear_in();
    slot0(1, 1, 7, 0, 0, 0, 0);
    step();
    clear_in();
    slot0(0, 1, 8, 1, 7, 0, 0);
    #1 check("lu_pop0", pop, 0);
    step();
    #1 check("lu_pop1", pop, 0);
    step();
    wwe[0] = 1; wlng[0] = 1; wwa[0] = 7; wwd[0] = 64'h77;
    #1 check("lu_wb_pop", pop, 1);
    step();

    // Stall hold captures a writeback.
    clear_in();
    slot0(0, 0, 0, 0, 0, 1, 2);
    step();
    stall = 1;
    wwe[0] = 1; wwa[0] = 2; wwd[0] = 64'hDEAD;
    step();
    wwe = '0;
    step();
    step();
    clear_in();
    #1;
    check("stall_exv", exv[0], 1);
    check("stall_op2", eo2[0], 64'hDEAD);
    step();

    // Two ports hit the same register: higher port wins.
    slot0(0, 0, 0, 1, 9, 0, 0);
    step();
    clear_in();
    wwe = '1; wwa[0] = 9; wwa[1] = 9; wwd[0] = 64'h1; wwd[1] = 64'h2;
    #1 check("wb_prio_op1", eo1[0], 64'h2);
    step();

    // Flush with stall and a pending load.
    clear_in();
    slot0(1, 1, 7, 0, 0, 0, 0);
    step();
    clear_in();
    slot0(0, 1, 8, 1, 7, 0, 0);
    stall = 1; flush = 1;
    #1 check("flush_pop", pop, 0);
    step();
    stall = 0; flush = 0;
    #1;
    check("flush_exv", exv, 0);
    check("flush_sb_pop", pop, 1);
    step();

    for (int i = 0; i < 400; i++) begin
      rand_in();
      step();
    end

    // Asynchronous reset mid-stream.
    rand_in();
    rst = 0; quiet = 1;
    #1;
    reset_check("midrst");
    clear_in();
    q.delete();
    for (int a = 0; a < NR; a++) pend[a] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    model_accept();
    quiet = 0;

    // r0 sources read zero even with a writeback to r0.
    slot0(0, 0, 0, 1, 0, 1, 0);
    wwe[0] = 1; wwa[0] = 0; wwd[0] = '1;
    step();
    clear_in();
    wwe[0] = 1; wwa[0] = 0; wwd[0] = '1;
    #1;
    check("r0_exv", exv[0], 1);
    check("r0_op1", eo1[0], 0);
    check("r0_op2", eo2[0], 0);
    step();

    for (int i = 0; i < 200; i++) begin
      rand_in();
      step();
    end

    clear_in();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
